// File: rtl/operand_bank.sv
// Multi-matrix operand register bank: byte-strobed host word access plus a
// handshaked row-per-beat stream of one matrix, row-major or transposed.
module operand_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_MAT    = 2,
    parameter int ELEM_WIDTH = 8,
    parameter int DIM        = 4,
    localparam int SEL_W     = (NUM_MAT > 1) ? $clog2(NUM_MAT) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [SEL_W-1:0]          mat_sel_i,
    input  logic [ADDR_WIDTH-1:0]     addr_Mat_i,
    input  logic [DATA_WIDTH-1:0]     write_data_Mat_i,
    input  logic                      write_en_Mat_i,
    input  logic [DATA_WIDTH/8-1:0]   write_strb_i,
    input  logic                      read_en_Mat_i,
    output logic [DATA_WIDTH-1:0]     read_data_Mat_o,
    output logic                      read_valid_o,
    output logic                      write_err_o,
    input  logic                      start_i,
    input  logic [SEL_W-1:0]          stream_mat_i,
    input  logic                      stream_mode_i,
    output logic [DIM*ELEM_WIDTH-1:0] stream_data_o,
    output logic                      stream_valid_o,
    input  logic                      stream_ready_i,
    output logic                      stream_last_o,
    output logic                      busy_o,
    output logic                      done_o
);

    localparam int DEPTH  = 2 ** ADDR_WIDTH;
    localparam int ROW_W  = DIM * ELEM_WIDTH;
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int BEAT_W = (DIM > 1) ? $clog2(DIM) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(DIM - 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_e;

    // Non-power-of-two NUM_MAT leaves unused select codes; those are rejected.
    function automatic logic sel_valid(input logic [SEL_W-1:0] sel);
        return (32'(sel) < 32'(NUM_MAT));
    endfunction

    logic [NUM_MAT-1:0][DEPTH-1:0][DATA_WIDTH-1:0] mem_r;
    state_e              state_r;
    state_e              state_nxt_s;
    logic [BEAT_W-1:0]   beat_r;
    logic [SEL_W-1:0]    stream_mat_r;
    logic                mode_r;
    logic [DATA_WIDTH-1:0] read_data_r;
    logic                read_valid_r;
    logic                write_err_r;
    logic                done_r;

    logic                wr_blocked_s;
    logic                wr_accept_s;
    logic [DATA_WIDTH-1:0] rd_word_s;
    logic                hs_s;
    logic                last_s;
    logic                busy_s;
    logic                done_set_s;
    logic [ROW_W-1:0]    stream_data_s;

    // Host write admission: unknown matrix, or the matrix currently streaming.
    always_comb begin
        wr_blocked_s = 1'b0;
        if (!sel_valid(mat_sel_i)) begin
            wr_blocked_s = 1'b1;
        end else if ((state_r == ST_STREAM) && (mat_sel_i == stream_mat_r)) begin
            wr_blocked_s = 1'b1;
        end else begin
            wr_blocked_s = 1'b0;
        end
        wr_accept_s = write_en_Mat_i & ~wr_blocked_s;
    end

    // Operand storage with per-byte write strobes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_r <= '0;
        end else begin
            for (int m = 0; m < NUM_MAT; m++) begin
                for (int b = 0; b < STRB_W; b++) begin
                    if (wr_accept_s && (mat_sel_i == SEL_W'(m)) && write_strb_i[b]) begin
                        mem_r[m][addr_Mat_i][b*8 +: 8] <= write_data_Mat_i[b*8 +: 8];
                    end
                end
            end
        end
    end

    // Host read mux; an out-of-range matrix select matches nothing and reads 0.
    always_comb begin
        rd_word_s = '0;
        for (int m = 0; m < NUM_MAT; m++) begin
            rd_word_s |= (mat_sel_i == SEL_W'(m)) ? mem_r[m][addr_Mat_i] : '0;
        end
    end

    // Host read/response registers; storage is sampled before the same-edge write.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            read_data_r  <= '0;
            read_valid_r <= 1'b0;
            write_err_r  <= 1'b0;
        end else begin
            read_valid_r <= read_en_Mat_i;
            write_err_r  <= write_en_Mat_i & wr_blocked_s;
            if (read_en_Mat_i) begin
                read_data_r <= rd_word_s;
            end
        end
    end

    // Stream FSM state register, beat counter and latched stream parameters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r      <= ST_IDLE;
            beat_r       <= '0;
            stream_mat_r <= '0;
            mode_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            done_r  <= done_set_s;
            case (state_r)
                ST_IDLE: begin
                    if (start_i && sel_valid(stream_mat_i)) begin
                        stream_mat_r <= stream_mat_i;
                        mode_r       <= stream_mode_i;
                        beat_r       <= '0;
                    end
                end
                ST_STREAM: begin
                    if (hs_s) begin
                        beat_r <= last_s ? '0 : (beat_r + BEAT_W'(1));
                    end
                end
                default: beat_r <= '0;
            endcase
        end
    end

    // Stream FSM next-state logic.
    always_comb begin
        hs_s        = (state_r == ST_STREAM) & stream_ready_i;
        last_s      = (beat_r == LAST_BEAT);
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_i && sel_valid(stream_mat_i)) begin
                    state_nxt_s = ST_STREAM;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (hs_s && last_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_STREAM;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Stream FSM outputs; an invalid start completes immediately with done.
    always_comb begin
        busy_s     = 1'b0;
        done_set_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                busy_s     = 1'b0;
                done_set_s = start_i & ~sel_valid(stream_mat_i);
            end
            ST_STREAM: begin
                busy_s     = 1'b1;
                done_set_s = hs_s & last_s;
            end
            default: begin
                busy_s     = 1'b0;
                done_set_s = 1'b0;
            end
        endcase
    end

    // Beat data straight from storage; exactly one (matrix, beat) term is live.
    always_comb begin
        stream_data_s = '0;
        for (int m = 0; m < NUM_MAT; m++) begin
            for (int k = 0; k < DIM; k++) begin
                stream_data_s |= ((stream_mat_r == SEL_W'(m)) && (beat_r == BEAT_W'(k)) && !mode_r)
                               ? mem_r[m][k][ROW_W-1:0] : '0;
                for (int j = 0; j < DIM; j++) begin
                    stream_data_s[j*ELEM_WIDTH +: ELEM_WIDTH] |=
                        ((stream_mat_r == SEL_W'(m)) && (beat_r == BEAT_W'(k)) && mode_r)
                        ? mem_r[m][j][k*ELEM_WIDTH +: ELEM_WIDTH] : '0;
                end
            end
        end
    end

    assign read_data_Mat_o = read_data_r;
    assign read_valid_o    = read_valid_r;
    assign write_err_o     = write_err_r;
    assign busy_o          = busy_s;
    assign stream_valid_o  = busy_s;
    assign stream_last_o   = busy_s & last_s;
    assign stream_data_o   = stream_data_s;
    assign done_o          = done_r;

endmodule

// File: doc/operand_bank.md
# operand_bank

Multi-matrix operand register bank: the parametrised successor to the single-matrix operand register in the matrix datapath. It holds NUM_MAT independent operand matrices with a host read/write port that supports byte strobes. A handshaked streaming port delivers a selected matrix to the multiply engine one row per beat, either row-major or transposed. The block sits between the host register interface and the matrix multiply core.

## Interface
Parameters:
- DATA_WIDTH, 32: host word width; multiple of 8.
- ADDR_WIDTH, 4: word address width per matrix; depth = 2**ADDR_WIDTH words.
- NUM_MAT, 2: number of matrices; ≥1.
- ELEM_WIDTH, 8: matrix element width.
- DIM, 4: matrix dimension. Constraints: DIM ≤ 2**ADDR_WIDTH and DIM*ELEM_WIDTH ≤ DATA_WIDTH.

Ports:
- Clocking: one clock; reset is asynchronous and active-low.
- clk_i, in, 1: clock; all state changes on the rising edge.
- rst_ni, in, 1: asynchronous active-low reset.
- mat_sel_i, in, max(1,$clog2(NUM_MAT)): host matrix select.
- addr_Mat_i, in, ADDR_WIDTH: host word address.
- write_data_Mat_i, in, DATA_WIDTH: host write data.
- write_en_Mat_i, in, 1: host write enable.
- write_strb_i, in, DATA_WIDTH/8: byte strobes; bit b enables bits [8b+7:8b].
- read_en_Mat_i, in, 1: host read request.
- read_data_Mat_o, out, DATA_WIDTH: registered host read data.
- read_valid_o, out, 1: read_data_Mat_o is valid this cycle.
- write_err_o, out, 1: one-cycle pulse when a write is rejected.
- start_i, in, 1: start a stream.
- stream_mat_i, in, same width as mat_sel_i: matrix to stream.
- stream_mode_i, in, 1: 0 = row-major, 1 = transposed.
- stream_data_o, out, DIM*ELEM_WIDTH: current beat.
- stream_valid_o, out, 1: beat valid.
- stream_ready_i, in, 1: consumer ready.
- stream_last_o, out, 1: current beat is beat DIM-1.
- busy_o, out, 1: stream in progress.
- done_o, out, 1: one-cycle pulse after the final handshake.

## Operation
- Storage is NUM_MAT × 2**ADDR_WIDTH words of DATA_WIDTH flops. Row r of matrix m is word r.
- Element j of a row occupies bits [j*ELEM_WIDTH +: ELEM_WIDTH].
- Host write: when write_en_Mat_i=1, strobed bytes of word [mat_sel_i][addr_Mat_i] are updated. Unstrobed bytes keep their value.
- A write is rejected (no storage change, write_err_o=1 for the next cycle) when either:
  - mat_sel_i ≥ NUM_MAT, or
  - busy_o=1 and mat_sel_i equals the latched stream matrix.
- Writes to other matrices during a stream are accepted.
- Host read: read_en_Mat_i=1 samples the address. Next cycle: read_valid_o=1 and read_data_Mat_o = the word.
  - Reads are allowed during a stream.
  - mat_sel_i ≥ NUM_MAT returns 0 with read_valid_o=1.
  - read_data_Mat_o holds its value when no read is requested.
- Simultaneous read and write to the same word returns the old data (read-before-write).
- Stream state machine:
  - IDLE: on start_i=1, latch stream_mat_i, stream_mode_i and beat=0, then go to STREAM. If stream_mat_i ≥ NUM_MAT, stay in IDLE and pulse done_o.
  - STREAM: stream_valid_o=1. On valid&ready with beat<DIM-1, increment beat. On valid&ready with beat=DIM-1, go to IDLE and pulse done_o.
  - start_i is ignored while in STREAM.
- Beat contents:
  - Row-major: beat k = row k, low DIM*ELEM_WIDTH bits.
  - Transposed: element j of beat k = element k of row j.
- stream_data_o is driven combinationally from storage, selected by beat. It is stable while a beat is stalled because writes to the streamed matrix are blocked.

## Timing
- Reset (asynchronous, any time):
  - All storage is cleared to 0.
  - FSM goes to IDLE and beat=0.
  - read_data_Mat_o=0, read_valid_o=0, write_err_o=0, stream_valid_o=0, stream_last_o=0, busy_o=0, done_o=0.
  - A reset mid-stream aborts the stream with no done_o.
- Write latency: the written data is visible to a read issued the next cycle.
- Read latency: 1 cycle.
- Stream timing:
  - start_i sampled at edge N gives busy_o=1 and stream_valid_o=1 from cycle N+1.
  - With ready held high, DIM beats arrive in DIM consecutive cycles.
  - done_o is high in the cycle after the last handshake; busy_o=0 in that same cycle.
  - Back-to-back: start_i may be asserted in the done_o cycle. The new stream begins on the following cycle.
- stream_last_o = stream_valid_o & (beat == DIM-1).
- stream_valid_o, once asserted, does not deassert until its handshake.

## Test plan
- Reset then read: rst_ni low, then read m0 addr 0 and m1 addr 15 -> read_data_Mat_o=0, read_valid_o=1 one cycle after each request.
- Strobed write: write m0 addr 2 = 0x11223344 with strb 4'hF, then write 0xAABBCCDD with strb 4'b0101 -> read m0 addr 2 returns 0x11BB33DD. Read m1 addr 2 returns 0.
- Row-major stream: m1 rows 0..3 = 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C; start mode 0 with ready=1 -> four beats in four cycles in that order, last on beat 3, done_o pulse after.
- Transposed stream with backpressure: same data, mode 1, ready toggling 1,0,0,1… -> beats 0x0C080400, 0x0D090501, 0x0E0A0602, 0x0F0B0703. Each beat is held stable through stalls.
- Write protection: during the m1 stream, write m1 addr 0 -> write_err_o pulse and no change. Write m0 addr 0 = 0x55 in the same window -> accepted and read back as 0x55.
- Reset mid-stream: assert rst_ni low after beat 1 -> busy_o, stream_valid_o and done_o all 0, storage reads 0. A subsequent start streams all-zero beats.
